// File: rtl/regfile_pkg.sv
// Shared register-file constants: address/data widths and CPSR flag positions.
// Imported by the register file, the writeback stage and decode.
package regfile_pkg;

  localparam int REG_ADDR_W     = 4;
  localparam int REG_COUNT      = 16;
  localparam int DATA_W         = 32;

  localparam int CPSR_N         = 31;
  localparam int CPSR_Z         = 30;
  localparam int CPSR_C         = 29;
  localparam int CPSR_V         = 28;
  localparam int CPSR_FLAGS_MSB = CPSR_N;
  localparam int CPSR_FLAGS_LSB = CPSR_V;
  localparam int CPSR_FLAGS_W   = CPSR_FLAGS_MSB - CPSR_FLAGS_LSB + 1;

  // Expand the stored NZCV nibble back to a full CPSR word.
  function automatic logic [DATA_W-1:0] pack_cpsr(input logic [CPSR_FLAGS_W-1:0] flags);
    return {flags, {(DATA_W - CPSR_FLAGS_W){1'b0}}};
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus one for the CPSR.
// A new issue wins over a writeback clear of the same bit in the same cycle.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_issue_en,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_issue_cpsr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_rd,
  input  logic                  i_clr_cpsr,
  input  logic [REG_ADDR_W-1:0] i_addr_a,
  input  logic [REG_ADDR_W-1:0] i_addr_b,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_busy_c
);

  logic [REG_COUNT-1:0] r_busy;
  logic                 r_busy_c;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_busy[gi] <= 1'b0;
        end else if (i_issue_en && (i_issue_rd == REG_ADDR_W'(gi))) begin
          r_busy[gi] <= 1'b1;
        end else if (i_clr_en && (i_clr_rd == REG_ADDR_W'(gi))) begin
          r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_c <= 1'b0;
    end else if (i_issue_en && i_issue_cpsr) begin
      r_busy_c <= 1'b1;
    end else if (i_clr_cpsr) begin
      r_busy_c <= 1'b0;
    end
  end

  assign o_busy_a = r_busy[i_addr_a];
  assign o_busy_b = r_busy[i_addr_b];
  assign o_busy_c = r_busy_c;

endmodule

// File: rtl/reg_file.sv
// Architectural register file + NZCV holder with RAW scoreboard for decode.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rd_num,
  input  logic                  rd_write_en,
  input  logic [DATA_W-1:0]     rd_val,
  input  logic                  cpsr_write_en,
  input  logic [DATA_W-1:0]     cpsr_in,
  input  logic [REG_ADDR_W-1:0] rn_num,
  input  logic [REG_ADDR_W-1:0] rm_num,
  output logic [DATA_W-1:0]     rn_val,
  output logic [DATA_W-1:0]     rm_val,
  output logic [DATA_W-1:0]     cpsr_val,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_cpsr,
  output logic                  busy_rn,
  output logic                  busy_rm,
  output logic                  busy_cpsr
);

  logic [DATA_W-1:0]       r_regs [REG_COUNT];
  logic [CPSR_FLAGS_W-1:0] r_nzcv;
  logic                    w_busy_a;
  logic                    w_busy_b;
  logic                    w_busy_c;
  logic [DATA_W-1:0]       w_cpsr_stored;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_regs
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_regs[gi] <= '0;
        end else if (rd_write_en && (rd_num == REG_ADDR_W'(gi))) begin
          r_regs[gi] <= rd_val;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nzcv <= '0;
    end else if (cpsr_write_en) begin
      r_nzcv <= cpsr_in[CPSR_FLAGS_MSB:CPSR_FLAGS_LSB];
    end
  end

  assign w_cpsr_stored = {r_nzcv, {(DATA_W - CPSR_FLAGS_W){1'b0}}};

  reg_scoreboard #(
    .REG_COUNT (REG_COUNT)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_issue_en   (issue_en),
    .i_issue_rd   (issue_rd),
    .i_issue_cpsr (issue_cpsr),
    .i_clr_en     (rd_write_en),
    .i_clr_rd     (rd_num),
    .i_clr_cpsr   (cpsr_write_en),
    .i_addr_a     (rn_num),
    .i_addr_b     (rm_num),
    .o_busy_a     (w_busy_a),
    .o_busy_b     (w_busy_b),
    .o_busy_c     (w_busy_c)
  );

`ifdef REGFILE_BYPASS_EN
  logic w_fwd_rn;
  logic w_fwd_rm;
  assign w_fwd_rn  = rd_write_en && (rd_num == rn_num);
  assign w_fwd_rm  = rd_write_en && (rd_num == rm_num);
  assign rn_val    = w_fwd_rn ? rd_val : r_regs[rn_num];
  assign rm_val    = w_fwd_rm ? rd_val : r_regs[rm_num];
  assign busy_rn   = w_busy_a & ~w_fwd_rn;
  assign busy_rm   = w_busy_b & ~w_fwd_rm;
  // The in-flight CPSR write is visible now, so its hazard is already resolved.
  assign cpsr_val  = cpsr_write_en
                   ? {cpsr_in[CPSR_FLAGS_MSB:CPSR_FLAGS_LSB], {(DATA_W - CPSR_FLAGS_W){1'b0}}}
                   : w_cpsr_stored;
  assign busy_cpsr = w_busy_c & ~cpsr_write_en;
`else
  assign rn_val    = r_regs[rn_num];
  assign rm_val    = r_regs[rm_num];
  assign busy_rn   = w_busy_a;
  assign busy_rm   = w_busy_b;
  assign cpsr_val  = w_cpsr_stored;
  assign busy_cpsr = w_busy_c;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_num;
  logic        rd_write_en;
  logic [31:0] rd_val;
  logic        cpsr_write_en;
  logic [31:0] cpsr_in;
  logic [3:0]  rn_num;
  logic [3:0]  rm_num;
  logic [31:0] rn_val;
  logic [31:0] rm_val;
  logic [31:0] cpsr_val;
  logic        issue_en;
  logic [3:0]  issue_rd;
  logic        issue_cpsr;
  logic        busy_rn;
  logic        busy_rm;
  logic        busy_cpsr;

  int checks   = 0;
  int failures = 0;

  reg_file #(.REG_COUNT(16), .DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_num        (rd_num),
    .rd_write_en   (rd_write_en),
    .rd_val        (rd_val),
    .cpsr_write_en (cpsr_write_en),
    .cpsr_in       (cpsr_in),
    .rn_num        (rn_num),
    .rm_num        (rm_num),
    .rn_val        (rn_val),
    .rm_val        (rm_val),
    .cpsr_val      (cpsr_val),
    .issue_en      (issue_en),
    .issue_rd      (issue_rd),
    .issue_cpsr    (issue_cpsr),
    .busy_rn       (busy_rn),
    .busy_rm       (busy_rm),
    .busy_cpsr     (busy_cpsr)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Advance past the next rising edge; inputs are then changed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_write_en   = 1'b0;
    cpsr_write_en = 1'b0;
    issue_en      = 1'b0;
    issue_cpsr    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rd_write_en = 1'b1; rd_num = 4'd3; rd_val = 32'h1111_2222;
    cpsr_write_en = 1'b1; cpsr_in = 32'hF000_0000;
    issue_en = 1'b1; issue_rd = 4'd3; issue_cpsr = 1'b1;
    rn_num = 4'd3; rm_num = 4'd0;
    tick(); tick();
    checks++;
    if (rn_val !== 32'h0 || rm_val !== 32'h0 || cpsr_val !== 32'h0) begin
      failures++;
      $display("FAIL reset_data rn=%h rm=%h cpsr=%h required 0", rn_val, rm_val, cpsr_val);
    end
    checks++;
    if ({busy_rn, busy_rm, busy_cpsr} !== 3'b000) begin
      failures++;
      $display("FAIL reset_busy got=%b required=000", {busy_rn, busy_rm, busy_cpsr});
    end
    $display("reset held: rn=%h cpsr=%h busy=%b", rn_val, cpsr_val, {busy_rn, busy_rm, busy_cpsr});
    idle();
    rst_n = 1'b1;
    rd_write_en = 1'b1; rd_num = 4'd3; rd_val = 32'hDEAD_BEEF;
    tick();
    idle();
    checks++;
    if (rn_val !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL first_write r3 got=%h required=deadbeef", rn_val);
    end
    $display("write r3: rn=%h", rn_val);
  endtask

  task automatic test_dual_write();
    rd_write_en = 1'b1; rd_num = 4'd5; rd_val = 32'h1234_5678;
    cpsr_write_en = 1'b1; cpsr_in = 32'hA5A5_A5A5;
    tick();
    idle();
    rn_num = 4'd5; rm_num = 4'd3;
    #1;
    checks++;
    if (rn_val !== 32'h1234_5678) begin
      failures++;
      $display("FAIL dual_r5 got=%h required=12345678", rn_val);
    end
    checks++;
    if (cpsr_val !== 32'hA000_0000) begin
      failures++;
      $display("FAIL dual_cpsr got=%h required=a0000000", cpsr_val);
    end
    checks++;
    if (rm_val !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL dual_rm_r3 got=%h required=deadbeef", rm_val);
    end
    $display("dual write: r5=%h cpsr=%h r3=%h", rn_val, cpsr_val, rm_val);
  endtask

  task automatic test_scoreboard();
    rn_num = 4'd7; rm_num = 4'd6;
    issue_en = 1'b1; issue_rd = 4'd7;
    tick();
    idle();
    checks++;
    if (busy_rn !== 1'b1 || busy_rm !== 1'b0) begin
      failures++;
      $display("FAIL sb_issue busy_rn=%b busy_rm=%b required 1,0", busy_rn, busy_rm);
    end
    $display("issue r7: busy_rn=%b busy_rm=%b", busy_rn, busy_rm);
    rd_write_en = 1'b1; rd_num = 4'd7; rd_val = 32'h55;
    tick();
    idle();
    checks++;
    if (busy_rn !== 1'b0 || rn_val !== 32'h55) begin
      failures++;
      $display("FAIL sb_clear busy_rn=%b rn=%h required 0,00000055", busy_rn, rn_val);
    end
    $display("writeback r7: busy_rn=%b rn=%h", busy_rn, rn_val);
    issue_en = 1'b1; issue_rd = 4'd7;
    rd_write_en = 1'b1; rd_num = 4'd7; rd_val = 32'h66;
    tick();
    idle();
    checks++;
    if (busy_rn !== 1'b1 || rn_val !== 32'h66) begin
      failures++;
      $display("FAIL sb_set_wins busy_rn=%b rn=%h required 1,00000066", busy_rn, rn_val);
    end
    $display("issue+writeback r7: busy_rn=%b rn=%h", busy_rn, rn_val);
    rd_write_en = 1'b1; rd_num = 4'd7; rd_val = 32'h66;
    tick();
    idle();
  endtask

  task automatic test_bypass();
    logic [31:0] exp_val;
    logic        exp_busy;
    rd_write_en = 1'b1; rd_num = 4'd2; rd_val = 32'h11;
    tick();
    idle();
    issue_en = 1'b1; issue_rd = 4'd2;
    tick();
    idle();
    rn_num = 4'd2; rm_num = 4'd2;
    rd_write_en = 1'b1; rd_num = 4'd2; rd_val = 32'h99;
    #1;
    exp_val  = BYPASS ? 32'h99 : 32'h11;
    exp_busy = BYPASS ? 1'b0 : 1'b1;
    checks++;
    if (rn_val !== exp_val || rm_val !== exp_val) begin
      failures++;
      $display("FAIL bypass_data rn=%h rm=%h required=%h", rn_val, rm_val, exp_val);
    end
    checks++;
    if (busy_rn !== exp_busy || busy_rm !== exp_busy) begin
      failures++;
      $display("FAIL bypass_busy rn=%b rm=%b required=%b", busy_rn, busy_rm, exp_busy);
    end
    $display("same-cycle write r2: rn=%h rm=%h busy_rn=%b", rn_val, rm_val, busy_rn);
    tick();
    idle();
    checks++;
    if (rn_val !== 32'h99 || busy_rn !== 1'b0) begin
      failures++;
      $display("FAIL bypass_after rn=%h busy_rn=%b required 00000099,0", rn_val, busy_rn);
    end
    $display("after edge r2: rn=%h busy_rn=%b", rn_val, busy_rn);
  endtask

  task automatic test_cpsr_hazard();
    logic [31:0] exp_cpsr;
    logic        exp_busy;
    issue_en = 1'b1; issue_rd = 4'd9; issue_cpsr = 1'b1;
    tick();
    idle();
    checks++;
    if (busy_cpsr !== 1'b1) begin
      failures++;
      $display("FAIL cpsr_issue busy_cpsr=%b required=1", busy_cpsr);
    end
    $display("issue cmp: busy_cpsr=%b", busy_cpsr);
    cpsr_write_en = 1'b1; cpsr_in = 32'h6000_0000;
    #1;
    exp_cpsr = BYPASS ? 32'h6000_0000 : 32'hA000_0000;
    exp_busy = BYPASS ? 1'b0 : 1'b1;
    checks++;
    if (cpsr_val !== exp_cpsr || busy_cpsr !== exp_busy) begin
      failures++;
      $display("FAIL cpsr_same_cycle cpsr=%h busy=%b required %h,%b", cpsr_val, busy_cpsr, exp_cpsr, exp_busy);
    end
    tick();
    idle();
    checks++;
    if (cpsr_val !== 32'h6000_0000 || busy_cpsr !== 1'b0) begin
      failures++;
      $display("FAIL cpsr_write cpsr=%h busy=%b required 60000000,0", cpsr_val, busy_cpsr);
    end
    $display("cpsr write: cpsr=%h busy_cpsr=%b", cpsr_val, busy_cpsr);
  endtask

  task automatic test_async_reset();
    rd_write_en = 1'b1; rd_num = 4'd1; rd_val = 32'h7;
    issue_en = 1'b1; issue_rd = 4'd4; issue_cpsr = 1'b1;
    tick();
    idle();
    rn_num = 4'd1; rm_num = 4'd4;
    #1;
    checks++;
    if (rn_val !== 32'h7 || busy_rm !== 1'b1 || busy_cpsr !== 1'b1) begin
      failures++;
      $display("FAIL pre_async rn=%h busy_rm=%b busy_cpsr=%b required 00000007,1,1", rn_val, busy_rm, busy_cpsr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rn_val !== 32'h0 || cpsr_val !== 32'h0 || {busy_rn, busy_rm, busy_cpsr} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset rn=%h cpsr=%h busy=%b required 0,0,000", rn_val, cpsr_val, {busy_rn, busy_rm, busy_cpsr});
    end
    $display("async reset: rn=%h busy=%b", rn_val, {busy_rn, busy_rm, busy_cpsr});
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (rn_val !== 32'h0 || busy_rm !== 1'b0) begin
      failures++;
      $display("FAIL post_async rn=%h busy_rm=%b required 0,0", rn_val, busy_rm);
    end
  endtask

  initial begin
    rn_num = '0; rm_num = '0; rd_num = '0; rd_val = '0; cpsr_in = '0; issue_rd = '0;
    test_reset();
    test_dual_write();
    test_scoreboard();
    test_bypass();
    test_cpsr_hazard();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
